bram_burst_ctrl: RTL and testbench

Parametrised burst controller between datapath engines and a single-port BRAM, succeeding the single-beat BRAM controller. It accepts one read or write burst command at a time, generates sequential word addresses, and applies per-byte write strobes. It absorbs a configurable BRAM read latency and buffers read data in a credit-managed output FIFO, so consumers may apply backpressure without losing data.

---
 rtl/bram_burst_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_bram_burst_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_burst_ctrl.sv
// bram_burst_ctrl: burst controller between datapath engines and a single-port BRAM.
// Accepts one read or write burst at a time and walks sequential word addresses.
// Reads pass through a MEM_LAT-deep tracking pipe into a credit-managed
// first-word-fall-through FIFO, so consumers may stall without losing data.
// Optional feature macro: BRAM_CTRL_PERF_CNT_EN adds saturating beat counters.

module bram_burst_ctrl #(
  parameter int DAT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int MEM_LAT    = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int NUM_BYTE  = DAT_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DAT_WIDTH-1:0]  wdat,
  input  logic [NUM_BYTE-1:0]   wstrb,
  input  logic                  wval,
  output logic                  wrdy,
  output logic [DAT_WIDTH-1:0]  rdat,
  output logic                  rval,
  output logic                  rlast,
  input  logic                  rrdy,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DAT_WIDTH-1:0]  mem_idat,
  input  logic [DAT_WIDTH-1:0]  mem_odat,
  output logic                  mem_enb,
  output logic                  mem_rst,
  output logic [NUM_BYTE-1:0]   mem_wen
`ifdef BRAM_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]           perf_wr_beats,
  output logic [31:0]           perf_rd_beats
`endif
);

  // Occupancy and in-flight counters must be able to hold FIFO_DEPTH itself.
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;

  // Held low through reset so cmd_ready only rises on the first edge afterwards.
  logic                   init_done;

  logic [ADDR_WIDTH-1:0]  addr_cnt;
  logic [LEN_WIDTH-1:0]   beat_cnt;
  logic                   last_beat;

  logic                   cmd_fire;
  logic                   wr_beat;
  logic                   rd_issue;
  logic                   credit_ok;
  logic [CNT_W:0]         credit_sum;

  logic [MEM_LAT-1:0]     vld_pipe;
  logic [MEM_LAT-1:0]     last_pipe;
  logic [CNT_W-1:0]       inflight_cnt;

  logic [DAT_WIDTH-1:0]   fifo_dat [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  fifo_last;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       fifo_cnt;
  logic                   fifo_push;
  logic                   fifo_pop;

  assign last_beat  = (beat_cnt == '0);

  // A read may only be issued if its data is guaranteed a FIFO slot on arrival,
  // counting both stored entries and reads still travelling through the BRAM.
  assign credit_sum = {1'b0, fifo_cnt} + {1'b0, inflight_cnt};
  assign credit_ok  = (credit_sum < (CNT_W + 1)'(FIFO_DEPTH));

  assign mem_addr   = addr_cnt;
  assign mem_rst    = 1'b0;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // One-shot flag enabling command acceptance once reset has been released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
    end
  end

  // Next-state logic and combinational BRAM/handshake drive.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    cmd_fire  = 1'b0;
    wrdy      = 1'b0;
    wr_beat   = 1'b0;
    rd_issue  = 1'b0;
    mem_enb   = 1'b0;
    mem_wen   = '0;
    mem_idat  = '0;
    case (state)
      IDLE: begin
        cmd_ready = init_done;
        if (cmd_valid && init_done) begin
          cmd_fire  = 1'b1;
          state_nxt = cmd_wr ? WRITE : READ;
        end
      end
      WRITE: begin
        wrdy = 1'b1;
        if (wval) begin
          wr_beat  = 1'b1;
          mem_enb  = 1'b1;
          mem_wen  = wstrb;
          mem_idat = wdat;
          if (last_beat) begin
            state_nxt = IDLE;
          end
        end
      end
      READ: begin
        if (credit_ok) begin
          rd_issue = 1'b1;
          mem_enb  = 1'b1;
          if (last_beat) begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Address and beat counters: loaded on a command, stepped on every beat/issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cnt <= '0;
      beat_cnt <= '0;
    end else if (cmd_fire) begin
      addr_cnt <= cmd_addr;
      beat_cnt <= cmd_len;
    end else if (wr_beat || rd_issue) begin
      addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
      beat_cnt <= beat_cnt - LEN_WIDTH'(1);
    end
  end

  // Latency pipe tracking which cycles carry valid BRAM read data and the last flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[0]  <= rd_issue;
      last_pipe[0] <= rd_issue & last_beat;
      for (int i = 1; i < MEM_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  assign fifo_push = vld_pipe[MEM_LAT-1];
  assign fifo_pop  = rval & rrdy;

  // Count of reads issued to the BRAM whose data has not yet entered the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_cnt <= '0;
    end else begin
      case ({rd_issue, fifo_push})
        2'b10:   inflight_cnt <= inflight_cnt + CNT_W'(1);
        2'b01:   inflight_cnt <= inflight_cnt - CNT_W'(1);
        default: inflight_cnt <= inflight_cnt;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_dat[wr_ptr]  <= mem_odat;
      fifo_last[wr_ptr] <= last_pipe[MEM_LAT-1];
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign rval  = (fifo_cnt != '0);
  assign rdat  = rval ? fifo_dat[rd_ptr] : '0;
  assign rlast = rval & fifo_last[rd_ptr];
  assign busy  = (state != IDLE) | (inflight_cnt != '0) | (fifo_cnt != '0);

`ifdef BRAM_CTRL_PERF_CNT_EN
  // Saturating counters of write-beat and read-pop handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_wr_beats <= '0;
      perf_rd_beats <= '0;
    end else begin
      if (wr_beat && (perf_wr_beats != 32'hFFFF_FFFF)) begin
        perf_wr_beats <= perf_wr_beats + 32'd1;
      end
      if (fifo_pop && (perf_rd_beats != 32'hFFFF_FFFF)) begin
        perf_rd_beats <= perf_rd_beats + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bram_burst_ctrl.sv
// tb_bram_burst_ctrl: directed bench for bram_burst_ctrl.
// Main instance (8-bit addresses) talks to a behavioural 1-cycle BRAM; a second
// instance with 4-bit addresses exercises address wrap and mid-burst reset.

module tb_bram_burst_ctrl;

  logic        clk;
  int          checks;
  int          failures;

  // Main instance signals
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [7:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wdat;
  logic [3:0]  wstrb;
  logic        wval, wrdy;
  logic [31:0] rdat;
  logic        rval, rlast, rrdy, busy;
  logic [7:0]  mem_addr;
  logic [31:0] mem_idat, mem_odat;
  logic        mem_enb, mem_rst;
  logic [3:0]  mem_wen;

  // Wrap instance signals
  logic        w_rst;
  logic        w_cmd_valid, w_cmd_ready, w_cmd_wr;
  logic [3:0]  w_cmd_addr;
  logic [7:0]  w_cmd_len;
  logic [31:0] w_wdat;
  logic [3:0]  w_wstrb;
  logic        w_wval, w_wrdy;
  logic [31:0] w_rdat;
  logic        w_rval, w_rlast, w_rrdy, w_busy;
  logic [3:0]  w_mem_addr;
  logic [31:0] w_mem_idat;
  logic [31:0] w_mem_odat;
  logic        w_mem_enb, w_mem_rst;
  logic [3:0]  w_mem_wen;

`ifdef BRAM_CTRL_PERF_CNT_EN
  logic [31:0] perf_wr_beats, perf_rd_beats;
  logic [31:0] w_perf_wr_beats, w_perf_rd_beats;
`endif

  assign w_mem_odat = 32'h0;

  bram_burst_ctrl #(
    .DAT_WIDTH(32), .ADDR_WIDTH(8), .LEN_WIDTH(8), .MEM_LAT(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdat(wdat), .wstrb(wstrb), .wval(wval), .wrdy(wrdy),
    .rdat(rdat), .rval(rval), .rlast(rlast), .rrdy(rrdy), .busy(busy),
    .mem_addr(mem_addr), .mem_idat(mem_idat), .mem_odat(mem_odat),
    .mem_enb(mem_enb), .mem_rst(mem_rst), .mem_wen(mem_wen)
`ifdef BRAM_CTRL_PERF_CNT_EN
    , .perf_wr_beats(perf_wr_beats), .perf_rd_beats(perf_rd_beats)
`endif
  );

  bram_burst_ctrl #(
    .DAT_WIDTH(32), .ADDR_WIDTH(4), .LEN_WIDTH(8), .MEM_LAT(1), .FIFO_DEPTH(4)
  ) dut_wrap (
    .clk(clk), .rst(w_rst),
    .cmd_valid(w_cmd_valid), .cmd_ready(w_cmd_ready), .cmd_wr(w_cmd_wr),
    .cmd_addr(w_cmd_addr), .cmd_len(w_cmd_len),
    .wdat(w_wdat), .wstrb(w_wstrb), .wval(w_wval), .wrdy(w_wrdy),
    .rdat(w_rdat), .rval(w_rval), .rlast(w_rlast), .rrdy(w_rrdy), .busy(w_busy),
    .mem_addr(w_mem_addr), .mem_idat(w_mem_idat), .mem_odat(w_mem_odat),
    .mem_enb(w_mem_enb), .mem_rst(w_mem_rst), .mem_wen(w_mem_wen)
`ifdef BRAM_CTRL_PERF_CNT_EN
    , .perf_wr_beats(w_perf_wr_beats), .perf_rd_beats(w_perf_rd_beats)
`endif
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural single-port BRAM with byte enables and one cycle of read latency.
  logic [31:0] bram [256];
  always @(posedge clk) begin
    if (mem_enb) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wen[b]) bram[mem_addr][8*b +: 8] <= mem_idat[8*b +: 8];
      end
      mem_odat <= bram[mem_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a command to the main instance for one cycle; returns in cycle C+1.
  task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    #1;
    checkOutput("cmd_ready_at_cmd", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Full-rate write burst with per-beat checks of the BRAM drive.
  task automatic writeBurst(input logic [7:0] addr, input logic [7:0] len,
                            input logic [3:0] strb, input logic [31:0] base);
    applyStimulus(1'b1, addr, len);
    for (int i = 0; i <= int'(len); i++) begin
      wval  = 1'b1;
      wdat  = base + 32'(i);
      wstrb = strb;
      #1;
      checkOutput("wr_wrdy", 32'(wrdy), 32'd1);
      checkOutput("wr_enb", 32'(mem_enb), 32'd1);
      checkOutput("wr_addr", 32'(mem_addr), 32'(addr) + 32'(i));
      checkOutput("wr_wen", 32'(mem_wen), 32'(strb));
      checkOutput("wr_idat", mem_idat, base + 32'(i));
      tick();
    end
    wval = 1'b0;
    #1;
    checkOutput("wr_ready_back", 32'(cmd_ready), 32'd1);
    checkOutput("wr_enb_idle", 32'(mem_enb), 32'd0);
    tick();
  endtask

  // Read burst with rrdy held high; checks latency, data, rlast and busy drop.
  task automatic readExpect(input logic [7:0] addr, input logic [7:0] len,
                            input logic [31:0] base, input string tag);
    int n;
    int k;
    n = 0;
    k = 1;
    rrdy = 1'b1;
    applyStimulus(1'b0, addr, len);
    while ((k <= int'(len) + 20) && (n <= int'(len))) begin
      #1;
      if (rval) begin
        if (n == 0) checkOutput({tag, "_first_rval_cycle"}, 32'(k), 32'd3);
        checkOutput({tag, "_rdat"}, rdat, base + 32'(n));
        checkOutput({tag, "_rlast"}, 32'(rlast), 32'(n == int'(len)));
        if (n == int'(len)) checkOutput({tag, "_last_cycle"}, 32'(k), 32'(3 + int'(len)));
        n++;
      end
      tick();
      k++;
    end
    checkOutput({tag, "_beats"}, 32'(n), 32'(int'(len) + 1));
    #1;
    checkOutput({tag, "_busy_done"}, 32'(busy), 32'd0);
    checkOutput({tag, "_rval_done"}, 32'(rval), 32'd0);
    tick();
  endtask

  initial begin
    logic [3:0] wrap_exp [4];
    int issues;
    int n;
    checks   = 0;
    failures = 0;
    wrap_exp[0] = 4'hE; wrap_exp[1] = 4'hF; wrap_exp[2] = 4'h0; wrap_exp[3] = 4'h1;

    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdat = '0; wstrb = '0; wval = 1'b0; rrdy = 1'b0;
    w_rst = 1'b1; w_cmd_valid = 1'b0; w_cmd_wr = 1'b0; w_cmd_addr = '0; w_cmd_len = '0;
    w_wdat = '0; w_wstrb = '0; w_wval = 1'b0; w_rrdy = 1'b0;

    // Reset values
    #12;
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rst_wrdy", 32'(wrdy), 32'd0);
    checkOutput("rst_rval", 32'(rval), 32'd0);
    checkOutput("rst_rlast", 32'(rlast), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_mem_enb", 32'(mem_enb), 32'd0);
    checkOutput("rst_mem_wen", 32'(mem_wen), 32'd0);
    checkOutput("rst_rdat", rdat, 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_idat", mem_idat, 32'd0);
    checkOutput("rst_mem_rst", 32'(mem_rst), 32'd0);

    @(negedge clk);
    rst   = 1'b0;
    w_rst = 1'b0;
    #1;
    checkOutput("rel_cmd_ready_low", 32'(cmd_ready), 32'd0);
    tick();
    checkOutput("rel_cmd_ready_rise", 32'(cmd_ready), 32'd1);

    // Write 0xA0..0xA3 to 0x10..0x13, then read them back
    $display("[TB] write burst 0x10 len 3");
    writeBurst(8'h10, 8'd3, 4'hF, 32'h0000_00A0);
    $display("[TB] read burst 0x10 len 3");
    readExpect(8'h10, 8'd3, 32'h0000_00A0, "rd");

    // Partial write over an all-ones word
    $display("[TB] partial write at 0x20");
    writeBurst(8'h20, 8'd0, 4'hF, 32'hFFFF_FFFF);
    writeBurst(8'h20, 8'd0, 4'h5, 32'h1122_3344);
    readExpect(8'h20, 8'd0, 32'hFF22_FF44, "partial");

    // Backpressure: 8-beat read with consumer stalled
    $display("[TB] backpressure read");
    writeBurst(8'h40, 8'd7, 4'hF, 32'h0000_00B0);
    rrdy = 1'b0;
    applyStimulus(1'b0, 8'h40, 8'd7);
    issues = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (mem_enb) issues++;
      tick();
    end
    checkOutput("bp_stalled_issues", 32'(issues), 32'd4);
    #1;
    checkOutput("bp_rval_held", 32'(rval), 32'd1);
    checkOutput("bp_head", rdat, 32'h0000_00B0);
    checkOutput("bp_busy", 32'(busy), 32'd1);
    tick();
    rrdy = 1'b1;
    n = 0;
    for (int k = 0; (k < 40) && (n < 8); k++) begin
      #1;
      if (mem_enb) issues++;
      if (rval) begin
        checkOutput("bp_rdat", rdat, 32'h0000_00B0 + 32'(n));
        checkOutput("bp_rlast", 32'(rlast), 32'(n == 7));
        n++;
      end
      tick();
    end
    checkOutput("bp_beats", 32'(n), 32'd8);
    checkOutput("bp_total_issues", 32'(issues), 32'd8);
    #1;
    checkOutput("bp_busy_done", 32'(busy), 32'd0);
    tick();

    // Address wrap on the 4-bit instance
    $display("[TB] wrap burst 0xE len 3");
    w_cmd_valid = 1'b1; w_cmd_wr = 1'b1; w_cmd_addr = 4'hE; w_cmd_len = 8'd3;
    #1;
    checkOutput("wrap_cmd_ready", 32'(w_cmd_ready), 32'd1);
    tick();
    w_cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_wval = 1'b1; w_wdat = 32'(i); w_wstrb = 4'hF;
      #1;
      checkOutput("wrap_addr", 32'(w_mem_addr), 32'(wrap_exp[i]));
      checkOutput("wrap_enb", 32'(w_mem_enb), 32'd1);
      tick();
    end
    w_wval = 1'b0;

    // Reset pulsed after the second beat of a burst
    $display("[TB] mid-burst reset");
    w_cmd_valid = 1'b1; w_cmd_wr = 1'b1; w_cmd_addr = 4'hE; w_cmd_len = 8'd3;
    tick();
    w_cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w_wval = 1'b1; w_wdat = 32'hC0 + 32'(i); w_wstrb = 4'hF;
      tick();
    end
    w_rst = 1'b1;
    #1;
    checkOutput("mrst_cmd_ready", 32'(w_cmd_ready), 32'd0);
    checkOutput("mrst_wrdy", 32'(w_wrdy), 32'd0);
    checkOutput("mrst_busy", 32'(w_busy), 32'd0);
    checkOutput("mrst_mem_enb", 32'(w_mem_enb), 32'd0);
    checkOutput("mrst_mem_wen", 32'(w_mem_wen), 32'd0);
    checkOutput("mrst_mem_addr", 32'(w_mem_addr), 32'd0);
    checkOutput("mrst_mem_idat", w_mem_idat, 32'd0);
    checkOutput("mrst_rval", 32'(w_rval), 32'd0);
    checkOutput("mrst_rlast", 32'(w_rlast), 32'd0);
    checkOutput("mrst_rdat", w_rdat, 32'd0);
    checkOutput("mrst_mem_rst", 32'(w_mem_rst), 32'd0);
    w_wval = 1'b0;
    #1;
    w_rst = 1'b0;
    #1;
    checkOutput("mrst_ready_before_edge", 32'(w_cmd_ready), 32'd0);
    tick();
    w_cmd_valid = 1'b1; w_cmd_wr = 1'b1; w_cmd_addr = 4'h3; w_cmd_len = 8'd0;
    #1;
    checkOutput("mrst_new_cmd_ready", 32'(w_cmd_ready), 32'd1);
    tick();
    w_cmd_valid = 1'b0;
    w_wval = 1'b1; w_wdat = 32'h55; w_wstrb = 4'h3;
    #1;
    checkOutput("mrst_new_addr", 32'(w_mem_addr), 32'h3);
    checkOutput("mrst_new_wen", 32'(w_mem_wen), 32'h3);
    checkOutput("mrst_new_enb", 32'(w_mem_enb), 32'd1);
    tick();
    w_wval = 1'b0;
    #1;
    checkOutput("mrst_new_done", 32'(w_cmd_ready), 32'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
